// File: rtl/pc_seq_pkg.sv
// Shared types for the pc_seq program-counter sequencer.
package pc_seq_pkg;

  // Encodings 6 and 7 are reserved and behave as OpHold.
  typedef enum logic [2:0] {
    OpNext   = 3'd0,
    OpJump   = 3'd1,
    OpBranch = 3'd2,
    OpCall   = 3'd3,
    OpRet    = 3'd4,
    OpHold   = 3'd5
  } pc_op_t;

endpackage

// File: rtl/pc_seq_ras.sv
// Circular return-address stack: a full push overwrites the oldest entry.
module pc_seq_ras #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned RAS_DEPTH = 4,
  localparam int unsigned PTR_W    = $clog2(RAS_DEPTH),
  localparam int unsigned CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CNT_W-1:0]  cnt,
  output logic              full,
  output logic              empty
);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  wp_q, wp_d, top_idx;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  assign full    = (cnt_q == CNT_W'(RAS_DEPTH));
  assign empty   = (cnt_q == '0);
  assign cnt     = cnt_q;
  assign top_idx = wp_q - PTR_W'(1);
  assign top     = mem_q[top_idx];

  // Power-of-two depth lets the write pointer wrap naturally.
  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    if (push) begin
      wp_d = wp_q + PTR_W'(1);
      if (!full) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !empty) begin
      wp_d  = top_idx;
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= push_data;
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer with sticky wrap/stack flags.
// Define PC_SEQ_RAS_EN to build in the return-address stack; otherwise CALL=JUMP, RET=NEXT.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 8,
  parameter int unsigned       RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  localparam int unsigned      CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              en,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] step,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] offset,
  input  logic              clr_flags,
  output logic [ADDR_W-1:0] pc,
  output logic              wrap,
  output logic              ras_ovf,
  output logic              ras_unf,
  output logic [CNT_W-1:0]  ras_cnt
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              wrap_q, wrap_set;
  logic [ADDR_W:0]   next_sum, br_sum;

  assign next_sum = {1'b0, pc_q} + {1'b0, step};
  assign br_sum   = {1'b0, pc_q} + {1'b0, offset};

`ifdef PC_SEQ_RAS_EN
  logic              push, pop, ras_full, ras_empty;
  logic [ADDR_W-1:0] ras_top;
  logic              ovf_q, unf_q, ovf_set, unf_set;

  pc_seq_ras #(
    .ADDR_W    (ADDR_W),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .pop       (pop),
    .push_data (next_sum[ADDR_W-1:0]),
    .top       (ras_top),
    .cnt       (ras_cnt),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_set | (ovf_q & ~(en & clr_flags));
      unf_q <= unf_set | (unf_q & ~(en & clr_flags));
    end
  end

  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;
`else
  assign ras_ovf = 1'b0;
  assign ras_unf = 1'b0;
  assign ras_cnt = '0;
`endif

  always_comb begin
    pc_d     = pc_q;
    wrap_set = 1'b0;
`ifdef PC_SEQ_RAS_EN
    push    = 1'b0;
    pop     = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
`endif
    if (en) begin
      case (op)
        OpNext: begin
          pc_d     = next_sum[ADDR_W-1:0];
          wrap_set = next_sum[ADDR_W];
        end
        OpJump: pc_d = target;
        OpBranch: begin
          pc_d     = br_sum[ADDR_W-1:0];
          // Negative offset: no carry-out means the result went below zero.
          wrap_set = offset[ADDR_W-1] ? ~br_sum[ADDR_W] : br_sum[ADDR_W];
        end
        OpCall: begin
          pc_d = target;
`ifdef PC_SEQ_RAS_EN
          push    = 1'b1;
          ovf_set = ras_full;
`endif
        end
        OpRet: begin
`ifdef PC_SEQ_RAS_EN
          if (!ras_empty) begin
            pc_d = ras_top;
            pop  = 1'b1;
          end else begin
            pc_d     = next_sum[ADDR_W-1:0];
            wrap_set = next_sum[ADDR_W];
            unf_set  = 1'b1;
          end
`else
          pc_d     = next_sum[ADDR_W-1:0];
          wrap_set = next_sum[ADDR_W];
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q   <= RESET_VEC;
      wrap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      wrap_q <= wrap_set | (wrap_q & ~(en & clr_flags));
    end
  end

  assign pc   = pc_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed vector table, reset corner case, random vs model.
module tb_pc_seq;
  import pc_seq_pkg::*;

  localparam int AW = 8;
  localparam int DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS = 1'b1;
`else
  localparam bit RAS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          en = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [AW-1:0] step = '0, target = '0, offset = '0;
  logic          clr_flags = 1'b0;
  logic [AW-1:0] pc;
  logic          wrap, ras_ovf, ras_unf;
  logic [2:0]    ras_cnt;

  int errors = 0;
  int checks = 0;

  pc_seq #(
    .ADDR_W    (AW),
    .RAS_DEPTH (DEPTH),
    .RESET_VEC (8'h00)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .op        (op),
    .step      (step),
    .target    (target),
    .offset    (offset),
    .clr_flags (clr_flags),
    .pc        (pc),
    .wrap      (wrap),
    .ras_ovf   (ras_ovf),
    .ras_unf   (ras_unf),
    .ras_cnt   (ras_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en;
    logic [2:0]    op;
    logic [AW-1:0] step, target, offset;
    logic          clr;
    logic [AW-1:0] pc;
    logic          wrap, ovf, unf;
    logic [2:0]    cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic [2:0] o, input logic [7:0] s, input logic [7:0] t,
                     input logic [7:0] f, input logic c, input logic [7:0] p, input logic w,
                     input logic ov, input logic un, input logic [2:0] n);
    vecs.push_back('{e, o, s, t, f, c, p, w, ov, un, n});
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] p, input logic w, input logic ov,
                         input logic un, input logic [2:0] n);
    chk({tag, ".pc"}, 32'(pc), 32'(p));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
    chk({tag, ".ovf"}, 32'(ras_ovf), 32'(ov));
    chk({tag, ".unf"}, 32'(ras_unf), 32'(un));
    chk({tag, ".cnt"}, 32'(ras_cnt), 32'(n));
  endtask

  task automatic apply(input logic e, input logic [2:0] o, input logic [7:0] s,
                       input logic [7:0] t, input logic [7:0] f, input logic c);
    @(negedge clk);
    en = e; op = o; step = s; target = t; offset = f; clr_flags = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    en = 1'b0;
    clr_flags = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Behavioural reference state.
  int m_pc;
  bit m_wrap, m_ovf, m_unf;
  int m_stk[$];

  function automatic void m_next(input int s);
    int r;
    r = m_pc + s;
    if (r > 255) m_wrap = 1'b1;
    m_pc = r % 256;
  endfunction

  function automatic void m_step(input logic e, input logic [2:0] o, input logic [7:0] s,
                                 input logic [7:0] t, input logic [7:0] f, input logic c);
    int r;
    if (!e) return;
    if (c) begin
      m_wrap = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end
    case (o)
      3'd0: m_next(int'(s));
      3'd1: m_pc = int'(t);
      3'd2: begin
        r = m_pc + int'($signed(f));
        if (r < 0 || r > 255) m_wrap = 1'b1;
        m_pc = (r + 256) % 256;
      end
      3'd3: begin
        if (RAS) begin
          if (m_stk.size() == DEPTH) begin
            void'(m_stk.pop_front());
            m_ovf = 1'b1;
          end
          m_stk.push_back((m_pc + int'(s)) % 256);
        end
        m_pc = int'(t);
      end
      3'd4: begin
        if (RAS && m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin
          m_next(int'(s));
          if (RAS) m_unf = 1'b1;
        end
      end
      default: ;
    endcase
  endfunction

  initial begin
    // Reset release and basic NEXT / hold
    add(1, OpNext, 1, 0, 0, 0, 8'h01, 0, 0, 0, 0);
    add(1, OpNext, 1, 0, 0, 0, 8'h02, 0, 0, 0, 0);
    add(1, OpNext, 1, 0, 0, 0, 8'h03, 0, 0, 0, 0);
    add(0, OpNext, 1, 0, 0, 0, 8'h03, 0, 0, 0, 0);
    add(0, OpJump, 1, 8'h77, 0, 0, 8'h03, 0, 0, 0, 0);
    // NEXT wrap, clear racing a set
    add(1, OpJump, 0, 8'hFE, 0, 0, 8'hFE, 0, 0, 0, 0);
    add(1, OpNext, 3, 0, 0, 0, 8'h01, 1, 0, 0, 0);
    add(1, OpJump, 0, 8'hFF, 0, 0, 8'hFF, 1, 0, 0, 0);
    add(1, OpNext, 1, 0, 0, 1, 8'h00, 1, 0, 0, 0);
    add(1, OpJump, 0, 8'h10, 0, 1, 8'h10, 0, 0, 0, 0);
    // BRANCH negative offsets
    add(1, OpBranch, 0, 0, 8'hF0, 0, 8'h00, 0, 0, 0, 0);
    add(1, OpBranch, 0, 0, 8'hFF, 0, 8'hFF, 1, 0, 0, 0);
    add(1, OpJump, 0, 8'h20, 0, 1, 8'h20, 0, 0, 0, 0);
    add(1, OpBranch, 0, 0, 8'h05, 0, 8'h25, 0, 0, 0, 0);
    add(1, OpJump, 0, 8'h20, 0, 0, 8'h20, 0, 0, 0, 0);
    if (RAS) begin
      add(1, OpCall, 1, 8'h80, 0, 0, 8'h80, 0, 0, 0, 1);
      add(1, OpCall, 1, 8'h81, 0, 0, 8'h81, 0, 0, 0, 2);
      add(1, OpCall, 1, 8'h82, 0, 0, 8'h82, 0, 0, 0, 3);
      add(1, OpCall, 1, 8'h83, 0, 0, 8'h83, 0, 0, 0, 4);
      add(1, OpCall, 1, 8'h84, 0, 0, 8'h84, 0, 1, 0, 4);
      add(1, OpRet, 1, 0, 0, 0, 8'h84, 0, 1, 0, 3);
      add(1, OpRet, 1, 0, 0, 0, 8'h83, 0, 1, 0, 2);
      add(1, OpRet, 1, 0, 0, 0, 8'h82, 0, 1, 0, 1);
      add(1, OpRet, 1, 0, 0, 0, 8'h81, 0, 1, 0, 0);
      add(1, OpRet, 1, 0, 0, 0, 8'h82, 0, 1, 1, 0);
      add(1, 3'd6, 1, 8'h11, 8'h11, 0, 8'h82, 0, 1, 1, 0);
      add(1, 3'd7, 1, 8'h11, 8'h11, 0, 8'h82, 0, 1, 1, 0);
      add(1, OpHold, 1, 8'h11, 8'h11, 0, 8'h82, 0, 1, 1, 0);
      add(1, OpJump, 0, 8'h00, 0, 1, 8'h00, 0, 0, 0, 0);
    end else begin
      add(1, OpCall, 1, 8'h80, 0, 0, 8'h80, 0, 0, 0, 0);
      add(1, OpCall, 1, 8'h84, 0, 0, 8'h84, 0, 0, 0, 0);
      add(1, OpRet, 1, 0, 0, 0, 8'h85, 0, 0, 0, 0);
      add(1, 3'd6, 1, 8'h11, 8'h11, 0, 8'h85, 0, 0, 0, 0);
      add(1, 3'd7, 1, 8'h11, 8'h11, 0, 8'h85, 0, 0, 0, 0);
      add(1, OpHold, 1, 8'h11, 8'h11, 0, 8'h85, 0, 0, 0, 0);
      add(1, OpCall, 1, 8'h40, 0, 0, 8'h40, 0, 0, 0, 0);
      add(1, OpRet, 2, 0, 0, 0, 8'h42, 0, 0, 0, 0);
      add(1, OpRet, 8'hC0, 0, 0, 0, 8'h02, 1, 0, 0, 0);
    end

    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    chk_all("reset", 8'h00, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      apply(vecs[i].en, vecs[i].op, vecs[i].step, vecs[i].target, vecs[i].offset, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].wrap, vecs[i].ovf, vecs[i].unf,
              vecs[i].cnt);
    end

    // Asynchronous reset while a CALL is waiting for its edge: the CALL is lost.
    apply(1, OpCall, 1, 8'h30, 0, 0);
    @(negedge clk);
    en = 1'b1; op = OpCall; step = 8'h01; target = 8'h40; clr_flags = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    chk_all("async_rst", 8'h00, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    chk_all("rst_held", 8'h00, 0, 0, 0, 0);
    apply(1, OpRet, 1, 0, 0, 0);
    chk_all("ret_after_rst", 8'h01, 0, 0, RAS, 0);

    // Random stimulus against the reference model
    do_reset();
    m_pc = 0; m_wrap = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
    for (int n = 0; n < 600; n++) begin
      logic          e, c;
      logic [2:0]    o;
      logic [AW-1:0] s, t, f;
      e = ($urandom_range(0, 9) != 0);
      o = 3'($urandom_range(0, 7));
      s = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      t = 8'($urandom);
      f = 8'($urandom);
      c = e && (o <= 3'd4) && ($urandom_range(0, 7) == 0);
      apply(e, o, s, t, f, c);
      m_step(e, o, s, t, f, c);
      chk_all($sformatf("rnd%0d", n), 8'(m_pc), m_wrap, m_ovf, m_unf, 3'(m_stk.size()));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, PC and address width in bits (>=2).
REQ-002 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_VEC, default 0, PC value loaded on reset.
REQ-004 SHALL have port clk  input  1  clock, rising-edge active.
REQ-005 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  advance enable; 0 = hold all state.
REQ-007 SHALL have port op  input  3  operation, pc_op_t: NEXT, JUMP, BRANCH, CALL, RET, HOLD.
REQ-008 SHALL have port step  input  ADDR_W  unsigned increment for NEXT, CALL return address and empty RET.
REQ-009 SHALL have port target  input  ADDR_W  absolute destination for JUMP/CALL.
REQ-010 SHALL have port offset  input  ADDR_W  two's-complement displacement for BRANCH.
REQ-011 SHALL have port clr_flags  input  1  synchronous clear of sticky flags.
REQ-012 SHALL have port pc  output  ADDR_W  current program counter.
REQ-013 SHALL have port wrap  output  1  sticky: NEXT/BRANCH crossed the 2^ADDR_W boundary.
REQ-014 SHALL have port ras_ovf  output  1  sticky: CALL pushed while stack full.
REQ-015 SHALL have port ras_unf  output  1  sticky: RET popped while stack empty.
REQ-016 SHALL have port ras_cnt  output  $clog2(RAS_DEPTH)+1  stack occupancy.

Function
REQ-017 SHALL update pc one cycle after the op-sampling edge; all outputs registered; no combinational input-to-output path.
REQ-018 SHALL hold pc, stack and flags unchanged when en=0 or op=HOLD; encodings 6-7 SHALL act as HOLD.
REQ-019 NEXT SHALL set pc <= (pc+step) mod 2^ADDR_W; set wrap on carry-out.
REQ-020 JUMP SHALL set pc <= target; wrap unaffected.
REQ-021 BRANCH SHALL set pc <= (pc+offset) mod 2^ADDR_W; set wrap when signed result leaves [0, 2^ADDR_W-1] (carry on positive offset, borrow on negative).
REQ-022 CALL SHALL push (pc+step) mod 2^ADDR_W, set pc <= target, increment ras_cnt.
REQ-023 CALL when ras_cnt==RAS_DEPTH SHALL overwrite the oldest entry (circular), keep ras_cnt, set ras_ovf.
REQ-024 RET with ras_cnt>0 SHALL set pc <= top entry and decrement ras_cnt (LIFO).
REQ-025 RET with ras_cnt==0 SHALL behave as NEXT (including wrap rule) and set ras_unf.
REQ-026 Sticky flags SHALL clear on clr_flags; a set event in the same cycle SHALL win.
REQ-027 Stack entries beyond ras_cnt SHALL be don't-care; no read of invalid entries SHALL reach pc.

Reset
REQ-028 rstn low SHALL asynchronously force pc=RESET_VEC, wrap=0, ras_ovf=0, ras_unf=0, ras_cnt=0, stack pointer=0.
REQ-029 Reset asserted mid-operation SHALL discard any in-flight op; first op after deassertion SHALL act on pc=RESET_VEC.
REQ-030 Stack storage SHALL NOT require reset.

Configuration
REQ-031 Macro PC_SEQ_RAS_EN defined SHALL compile in the return-address stack per REQ-022..027.
REQ-032 PC_SEQ_RAS_EN undefined SHALL make CALL act as JUMP, RET act as NEXT without setting ras_unf, tie ras_ovf, ras_unf, ras_cnt to 0, and instantiate no stack.

Structure
REQ-033 Package pc_seq_pkg SHALL hold pc_op_t enum and its encodings (NEXT=0, JUMP=1, BRANCH=2, CALL=3, RET=4, HOLD=5).
REQ-034 Stack SHALL be sub-module pc_seq_ras (push, pop, push_data, top, cnt, full, empty), parameterised by ADDR_W and RAS_DEPTH.
REQ-035 Sequencing, adder and flag logic SHALL live in pc_seq top level.

Verification (ADDR_W=8, RAS_DEPTH=4, RESET_VEC=0, PC_SEQ_RAS_EN defined unless stated)
REQ-036 Reset release, NEXT step=1 x3 -> pc 1,2,3; en=0 for 2 cycles -> pc stays 3.
REQ-037 pc=0xFE, NEXT step=3 -> pc=0x01, wrap=1; clr_flags with concurrent NEXT from 0xFF step=1 -> wrap stays 1.
REQ-038 pc=0x10, BRANCH offset=0xF0 (-16) -> pc=0x00, wrap=0; again offset=0xFF -> pc=0xFF, wrap=1.
REQ-039 pc=0x20, CALL target=0x80 step=1 x5 (targets 0x80..0x84) -> ras_cnt=4, ras_ovf=1; RET x4 -> pc 0x84,0x83,0x82,0x81; RET -> pc=0x82, ras_unf=1.
REQ-040 CALL target=0x40 then rstn pulse low mid-cycle -> pc=0x00, ras_cnt=0 immediately; following RET -> pc=0x01, ras_unf=1.
REQ-041 PC_SEQ_RAS_EN undefined: CALL target=0x40 -> pc=0x40, ras_cnt=0; RET step=2 -> pc=0x42, ras_unf=0.
